membus_arbiter: RTL and testbench
=================================

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64 (XLEN), request address width.
REQ-002 Parameter DATA_WIDTH, default 64 (MEMBUS_DATA_WIDTH), data width; wmask width is DATA_WIDTH/8.
REQ-003 Parameter DEPTH, default 4, maximum outstanding requests; power of two, at least 2.
REQ-004 Parameter STARVE_LIMIT, default 4, number of consecutive data wins before instruction is forced; at least 1.
REQ-005 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Ports i_valid/i_addr, input, 1/ADDR_WIDTH, instruction-fetch request (read only).
REQ-008 Ports i_ready/i_rvalid/i_rdata, output, 1/1/DATA_WIDTH, instruction accept, response strobe, response data.
REQ-009 Ports d_valid/d_addr/d_wen/d_wdata/d_wmask, input, 1/ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8, data request.
REQ-010 Ports d_ready/d_rvalid/d_rdata, output, 1/1/DATA_WIDTH, data accept, response strobe, response data.
REQ-011 Ports m_valid/m_addr/m_wen/m_wdata/m_wmask, output, same widths as data request, downstream (MMIO) request.
REQ-012 Ports m_ready/m_rvalid/m_rdata, input, 1/1/DATA_WIDTH, downstream accept, response strobe, response data.
REQ-013 Port outstanding, output, $clog2(DEPTH+1), number of accepted requests awaiting a response.
REQ-014 Port err_unexpected_rsp, output, 1, sticky flag set on a response with nothing outstanding.

Function
REQ-015 Downstream contract: every accepted request (read or write) yields exactly one m_rvalid pulse, in order, at least 1 cycle after acceptance.
REQ-016 full = (outstanding == DEPTH); m_valid = (i_valid | d_valid) & !full, combinational.
REQ-017 Grant: data wins when d_valid, except when i_valid and starve_cnt == STARVE_LIMIT, in which case instruction wins.
REQ-018 When no data request is pending, instruction wins whenever i_valid is high.
REQ-019 m_addr/m_wen/m_wdata/m_wmask follow the granted source; for an instruction grant, m_wen=0, m_wdata=0, m_wmask=0.
REQ-020 i_ready = m_ready & !full & (grant==I); d_ready = m_ready & !full & (grant==D); the losing source sees ready=0.
REQ-021 Accept = m_valid & m_ready; on accept the grant ID (I/D) is pushed to an in-order tag FIFO of DEPTH entries.
REQ-022 When full, no request is accepted, even if a pop occurs in the same cycle.
REQ-023 starve_cnt: on a D accept while i_valid is high, increment, saturating at STARVE_LIMIT; on an I accept, or when i_valid is low, clear to 0; otherwise hold.
REQ-024 On m_rvalid with FIFO non-empty: pop the head, and in the same cycle drive i_rvalid=1 if the head is I, otherwise d_rvalid=1.
REQ-025 i_rdata = d_rdata = m_rdata at all times; i_rvalid and d_rvalid are never both 1.
REQ-026 On a same-cycle push and pop, outstanding is unchanged and FIFO order is preserved; pointers wrap modulo DEPTH.
REQ-027 On m_rvalid with FIFO empty (including an empty FIFO with a push in the same cycle): no pop, i_rvalid=d_rvalid=0, err_unexpected_rsp set to 1 and held until reset.
REQ-028 outstanding is registered: it equals pushes minus pops since reset.

Reset
REQ-029 While rst=1, asynchronously clear: FIFO pointers, outstanding=0, starve_cnt=0, err_unexpected_rsp=0.
REQ-030 While rst=1, all ready/valid/rvalid outputs are 0.
REQ-031 Reset mid-operation discards all outstanding tags; later stray responses set err_unexpected_rsp per REQ-027.

Verification
REQ-032 Only i_valid=1, i_addr=0x8000_0000, m_ready=1, m_rvalid 1 cycle later with m_rdata=0x13 -> i_ready=1, m_wen=0, next cycle i_rvalid=1, i_rdata=0x13, d_rvalid=0, outstanding 1 then 0.
REQ-033 i_valid=d_valid=1 continuously with STARVE_LIMIT=4 and m_ready=1 -> grant sequence D,D,D,D,I,D,D,D,D,I; responses route in that order.
REQ-034 m_ready=1, no responses, 5 back-to-back D requests with DEPTH=4 -> 4 accepted, outstanding=4, m_valid=0 and d_ready=0 on the 5th; after one m_rvalid, the 5th is accepted in the following cycle.
REQ-035 outstanding=2 (tags I,D), same cycle: new D accept plus m_rvalid -> i_rvalid=1, outstanding stays 2, subsequent responses route D,D.
REQ-036 m_rvalid=1 with outstanding=0 -> no i_rvalid/d_rvalid, err_unexpected_rsp=1 and held; rst pulse -> err_unexpected_rsp=0, outstanding=0.

Source files
------------

// File: rtl/membus_arbiter.sv
// membus_arbiter: two-source (instruction/data) arbiter onto a single
// in-order memory/MMIO bus, with a tag FIFO routing responses back to
// the requester and a starvation counter that forces an instruction win.
module membus_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        i_valid,
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    output logic                        i_ready,
    output logic                        i_rvalid,
    output logic [DATA_WIDTH-1:0]       i_rdata,

    input  logic                        d_valid,
    input  logic [ADDR_WIDTH-1:0]       d_addr,
    input  logic                        d_wen,
    input  logic [DATA_WIDTH-1:0]       d_wdata,
    input  logic [DATA_WIDTH/8-1:0]     d_wmask,
    output logic                        d_ready,
    output logic                        d_rvalid,
    output logic [DATA_WIDTH-1:0]       d_rdata,

    output logic                        m_valid,
    output logic [ADDR_WIDTH-1:0]       m_addr,
    output logic                        m_wen,
    output logic [DATA_WIDTH-1:0]       m_wdata,
    output logic [DATA_WIDTH/8-1:0]     m_wmask,
    input  logic                        m_ready,
    input  logic                        m_rvalid,
    input  logic [DATA_WIDTH-1:0]       m_rdata,

    output logic [$clog2(DEPTH+1)-1:0]  outstanding,
    output logic                        err_unexpected_rsp
);

    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        TAG_I = 1'b0,
        TAG_D = 1'b1
    } tag_t;

    tag_t           tag_mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [SW-1:0]  starve_cnt;

    tag_t           grant;
    tag_t           head;
    logic           full;
    logic           empty;
    logic           starved;
    logic           push;
    logic           pop;

    // Grant selection, request forwarding and response routing
    always_comb begin
        full    = (outstanding == OW'(DEPTH));
        empty   = (outstanding == '0);
        starved = i_valid && (starve_cnt == SW'(STARVE_LIMIT));
        grant   = (d_valid && !starved) ? TAG_D : TAG_I;
        head    = tag_mem[rd_ptr];

        m_valid = !rst && (i_valid || d_valid) && !full;
        i_ready = !rst && m_ready && !full && (grant == TAG_I);
        d_ready = !rst && m_ready && !full && (grant == TAG_D);
        push    = m_valid && m_ready;
        pop     = !rst && m_rvalid && !empty;

        if (grant == TAG_D) begin
            m_addr  = d_addr;
            m_wen   = d_wen;
            m_wdata = d_wdata;
            m_wmask = d_wmask;
        end else begin
            m_addr  = i_addr;
            m_wen   = 1'b0;
            m_wdata = '0;
            m_wmask = '0;
        end

        i_rvalid = pop && (head == TAG_I);
        d_rvalid = pop && (head == TAG_D);
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end

    // Tag storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    // FIFO pointers, occupancy and the sticky protocol-error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            outstanding        <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            outstanding <= outstanding + OW'(push) - OW'(pop);
            if (m_rvalid && empty) begin
                err_unexpected_rsp <= 1'b1;
            end
        end
    end

    // Consecutive data wins while instruction waits, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!i_valid || (push && grant == TAG_I)) begin
            starve_cnt <= '0;
        end else if (push && grant == TAG_D) begin
            if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed testbench for membus_arbiter with hand-computed expectations.
module tb_membus_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_valid;
    logic [AW-1:0] d_addr;
    logic          d_wen;
    logic [DW-1:0] d_wdata;
    logic [7:0]    d_wmask;
    logic          d_ready;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [7:0]    m_wmask;
    logic          m_ready;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [2:0]    outstanding;
    logic          err_unexpected_rsp;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    membus_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (4),
        .STARVE_LIMIT(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_valid           (i_valid),
        .i_addr            (i_addr),
        .i_ready           (i_ready),
        .i_rvalid          (i_rvalid),
        .i_rdata           (i_rdata),
        .d_valid           (d_valid),
        .d_addr            (d_addr),
        .d_wen             (d_wen),
        .d_wdata           (d_wdata),
        .d_wmask           (d_wmask),
        .d_ready           (d_ready),
        .d_rvalid          (d_rvalid),
        .d_rdata           (d_rdata),
        .m_valid           (m_valid),
        .m_addr            (m_addr),
        .m_wen             (m_wen),
        .m_wdata           (m_wdata),
        .m_wmask           (m_wmask),
        .m_ready           (m_ready),
        .m_rvalid          (m_rvalid),
        .m_rdata           (m_rdata),
        .outstanding       (outstanding),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, well before the next edge
    task automatic settle();
        #2;
    endtask

    // Expected grant pattern under continuous contention (1 = data)
    logic [9:0] exp_d;

    initial begin
        exp_d = 10'b0111101111;   // index 0..9: D D D D I D D D D I

        rst      = 1'b1;
        i_valid  = 1'b1;
        i_addr   = '0;
        d_valid  = 1'b1;
        d_addr   = '0;
        d_wen    = 1'b0;
        d_wdata  = '0;
        d_wmask  = '0;
        m_ready  = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = '0;

        // Reset state with all requests asserted
        tick();
        settle();
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_i_ready", 64'(i_ready), 64'd0);
        check_eq("rst_d_ready", 64'(d_ready), 64'd0);
        check_eq("rst_i_rvalid", 64'(i_rvalid), 64'd0);
        check_eq("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        check_eq("rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("rst_err", 64'(err_unexpected_rsp), 64'd0);
        i_valid  = 1'b0;
        d_valid  = 1'b0;
        m_rvalid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single instruction fetch and its response
        i_valid = 1'b1;
        i_addr  = 64'h8000_0000;
        settle();
        check_eq("if_m_valid", 64'(m_valid), 64'd1);
        check_eq("if_i_ready", 64'(i_ready), 64'd1);
        check_eq("if_d_ready", 64'(d_ready), 64'd0);
        check_eq("if_m_wen", 64'(m_wen), 64'd0);
        check_eq("if_m_addr", m_addr, 64'h8000_0000);
        tick();
        i_valid = 1'b0;
        settle();
        check_eq("if_outstanding_1", 64'(outstanding), 64'd1);
        m_rvalid = 1'b1;
        m_rdata  = 64'h13;
        settle();
        check_eq("if_i_rvalid", 64'(i_rvalid), 64'd1);
        check_eq("if_i_rdata", i_rdata, 64'h13);
        check_eq("if_d_rvalid", 64'(d_rvalid), 64'd0);
        check_eq("if_d_rdata", d_rdata, 64'h13);
        tick();
        m_rvalid = 1'b0;
        settle();
        check_eq("if_outstanding_0", 64'(outstanding), 64'd0);
        check_eq("if_err", 64'(err_unexpected_rsp), 64'd0);

        // Continuous contention: starvation forces every fifth grant to I
        i_addr  = 64'h1000;
        d_addr  = 64'h2000;
        d_wen   = 1'b1;
        d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        d_wmask = 8'hFF;
        for (int k = 0; k <= 10; k++) begin
            i_valid  = (k < 10);
            d_valid  = (k < 10);
            m_rvalid = (k > 0);
            m_rdata  = 64'(k);
            settle();
            if (k < 10) begin
                check_eq($sformatf("starve_d_ready_%0d", k), 64'(d_ready), 64'(exp_d[k]));
                check_eq($sformatf("starve_i_ready_%0d", k), 64'(i_ready), 64'(!exp_d[k]));
                check_eq($sformatf("starve_m_addr_%0d", k), m_addr,
                         exp_d[k] ? 64'h2000 : 64'h1000);
                check_eq($sformatf("starve_m_wen_%0d", k), 64'(m_wen), 64'(exp_d[k]));
                check_eq($sformatf("starve_m_wdata_%0d", k), m_wdata,
                         exp_d[k] ? 64'hDEAD_BEEF_CAFE_F00D : 64'd0);
                check_eq($sformatf("starve_m_wmask_%0d", k), 64'(m_wmask),
                         exp_d[k] ? 64'hFF : 64'h00);
            end
            if (k > 0) begin
                check_eq($sformatf("starve_d_rvalid_%0d", k), 64'(d_rvalid), 64'(exp_d[k-1]));
                check_eq($sformatf("starve_i_rvalid_%0d", k), 64'(i_rvalid), 64'(!exp_d[k-1]));
            end
            tick();
        end
        i_valid  = 1'b0;
        d_valid  = 1'b0;
        m_rvalid = 1'b0;
        d_wen    = 1'b0;
        settle();
        check_eq("starve_outstanding_0", 64'(outstanding), 64'd0);

        // Back-pressure when the tag FIFO is full
        d_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq($sformatf("full_d_ready_%0d", k), 64'(d_ready), 64'd1);
            tick();
        end
        settle();
        check_eq("full_outstanding_4", 64'(outstanding), 64'd4);
        check_eq("full_m_valid", 64'(m_valid), 64'd0);
        check_eq("full_d_ready", 64'(d_ready), 64'd0);
        m_rvalid = 1'b1;
        settle();
        check_eq("full_pop_d_rvalid", 64'(d_rvalid), 64'd1);
        check_eq("full_pop_d_ready", 64'(d_ready), 64'd0);
        tick();
        m_rvalid = 1'b0;
        settle();
        check_eq("full_outstanding_3", 64'(outstanding), 64'd3);
        check_eq("full_5th_d_ready", 64'(d_ready), 64'd1);
        tick();
        d_valid = 1'b0;
        settle();
        check_eq("full_outstanding_4b", 64'(outstanding), 64'd4);
        m_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq($sformatf("drain_d_rvalid_%0d", k), 64'(d_rvalid), 64'd1);
            tick();
        end
        m_rvalid = 1'b0;
        settle();
        check_eq("drain_outstanding_0", 64'(outstanding), 64'd0);

        // Simultaneous push and pop keeps occupancy and order
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        d_valid = 1'b1;
        tick();
        settle();
        check_eq("pp_outstanding_2", 64'(outstanding), 64'd2);
        m_rvalid = 1'b1;
        settle();
        check_eq("pp_i_rvalid", 64'(i_rvalid), 64'd1);
        check_eq("pp_d_rvalid", 64'(d_rvalid), 64'd0);
        check_eq("pp_d_ready", 64'(d_ready), 64'd1);
        tick();
        d_valid = 1'b0;
        settle();
        check_eq("pp_outstanding_still_2", 64'(outstanding), 64'd2);
        for (int k = 0; k < 2; k++) begin
            settle();
            check_eq($sformatf("pp_route_d_%0d", k), 64'(d_rvalid), 64'd1);
            check_eq($sformatf("pp_route_i_%0d", k), 64'(i_rvalid), 64'd0);
            tick();
        end
        m_rvalid = 1'b0;
        settle();
        check_eq("pp_outstanding_0", 64'(outstanding), 64'd0);
        check_eq("pp_err", 64'(err_unexpected_rsp), 64'd0);

        // Stray response with nothing outstanding
        m_rvalid = 1'b1;
        settle();
        check_eq("stray_i_rvalid", 64'(i_rvalid), 64'd0);
        check_eq("stray_d_rvalid", 64'(d_rvalid), 64'd0);
        tick();
        m_rvalid = 1'b0;
        settle();
        check_eq("stray_err_set", 64'(err_unexpected_rsp), 64'd1);
        tick();
        settle();
        check_eq("stray_err_held", 64'(err_unexpected_rsp), 64'd1);

        // Reset mid-operation drops the outstanding tag
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        settle();
        check_eq("midrst_outstanding_1", 64'(outstanding), 64'd1);
        rst = 1'b1;
        settle();
        check_eq("midrst_async_err", 64'(err_unexpected_rsp), 64'd0);
        check_eq("midrst_async_outstanding", 64'(outstanding), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        m_rvalid = 1'b1;
        settle();
        check_eq("midrst_stray_i_rvalid", 64'(i_rvalid), 64'd0);
        tick();
        m_rvalid = 1'b0;
        settle();
        check_eq("midrst_stray_err", 64'(err_unexpected_rsp), 64'd1);
        check_eq("midrst_outstanding_0", 64'(outstanding), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
